// File: rtl/dbg_slave_pkg.sv
// Shared constants and types for the system-clock half of the CPU debug slave.
package dbg_slave_pkg;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  // Offsets of the ACT/SEL flags counted down from the top of the scan register.
  localparam int unsigned ACT_OFS = 3;
  localparam int unsigned SEL_OFS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StIssue,
    StStall
  } dbg_state_e;

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-stage synchroniser for a tck-domain level, with a single-cycle rising-edge pulse.
module dbg_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [Stages-1:0] sync_q;
  logic              edge_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      edge_q <= sync_q[Stages-1];
    end
  end

  assign rise_o = sync_q[Stages-1] & ~edge_q;

endmodule

// File: rtl/cpu_debug_slave_sysclk_mc.sv
// System-clock half of the CPU debug slave: strobe sync, jdo capture, action pulse issue.
// Optional overrun counter enabled by defining DBG_SLAVE_OVERRUN_CNT_EN.
module cpu_debug_slave_sysclk_mc
  import dbg_slave_pkg::*;
#(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned NUM_BRK     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                vs_uir,
  input  logic                vs_udr,
  input  logic                ocimem_ready,
  output logic [SR_WIDTH-1:0] jdo,
  output logic                take_action_ocimem_a,
  output logic                take_action_ocimem_b,
  output logic                take_no_action_ocimem_a,
  output logic [NUM_BRK-1:0]  take_action_brk,
  output logic [NUM_BRK-1:0]  take_no_action_brk,
  output logic                take_action_tracectrl,
  output logic                busy,
  output logic                cmd_err,
  output logic [7:0]          overrun_cnt
);

  localparam int unsigned ChBits = (NUM_BRK > 2) ? $clog2(NUM_BRK) : 1;

  logic              uir_rise, udr_rise;
  dbg_state_e        state_q, state_d;
  logic [1:0]        ir_lat_q;
  logic [SR_WIDTH-1:0] jdo_q;

  dbg_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_sync_uir (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (vs_uir),
    .rise_o (uir_rise)
  );

  dbg_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_sync_udr (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (vs_udr),
    .rise_o (udr_rise)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (udr_rise) state_d = StCapture;
      StCapture: state_d = StIssue;
      StIssue:   state_d = (ir_lat_q == IR_OCIMEM && !ocimem_ready) ? StStall : StIdle;
      StStall:   if (ocimem_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      ir_lat_q <= 2'b00;
      jdo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (uir_rise) ir_lat_q <= ir_in[1:0];
      if (state_q == StCapture) jdo_q <= sr;
    end
  end

  logic              act, sel, bact, idx_ok;
  logic [ChBits-1:0] brk_idx;
  logic              issue, ocimem_fire, brk_hit, overrun;

  assign act     = jdo_q[SR_WIDTH-ACT_OFS];
  assign sel     = jdo_q[SR_WIDTH-SEL_OFS];
  assign brk_idx = jdo_q[SR_WIDTH-1 -: ChBits];
  assign bact    = jdo_q[SR_WIDTH-ChBits-1];
  assign idx_ok  = 32'(brk_idx) < NUM_BRK;

  // Pulses are gated by reset so a stall aborted by reset never fires.
  assign issue       = reset_n && (state_q == StIssue);
  assign ocimem_fire = reset_n && ocimem_ready &&
                       ((state_q == StIssue && ir_lat_q == IR_OCIMEM) || state_q == StStall);
  assign brk_hit     = issue && (ir_lat_q == IR_BREAK) && idx_ok;
  assign overrun     = reset_n && udr_rise && (state_q != StIdle);

  assign take_action_ocimem_a    = ocimem_fire & act & ~sel;
  assign take_action_ocimem_b    = ocimem_fire & act & sel;
  assign take_no_action_ocimem_a = ocimem_fire & ~act;
  assign take_action_tracectrl   = issue && (ir_lat_q == IR_TRACECTRL) && act;

  always_comb begin
    take_action_brk    = '0;
    take_no_action_brk = '0;
    for (int unsigned i = 0; i < NUM_BRK; i++) begin
      if (brk_hit && 32'(brk_idx) == i) begin
        take_action_brk[i]    = bact;
        take_no_action_brk[i] = ~bact;
      end
    end
  end

  assign cmd_err = overrun || (issue && (ir_lat_q == IR_BREAK) && !idx_ok);
  assign busy    = (state_q != StIdle);
  assign jdo     = jdo_q;

`ifdef DBG_SLAVE_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovr_cnt_q <= 8'h00;
    end else if (overrun && ovr_cnt_q != 8'hff) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_debug_slave_sysclk_mc.sv
// Randomised self-checking bench for cpu_debug_slave_sysclk_mc against a command-level model.
module tb_cpu_debug_slave_sysclk_mc;

  localparam int unsigned SrW  = 38;
  localparam int unsigned Sync = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [1:0]     ir_in = 2'b00;
  logic [SrW-1:0] sr = '0;
  logic           vs_uir = 1'b0, vs_udr = 1'b0, ocimem_ready = 1'b1;

  logic [SrW-1:0] jdo, jdo3;
  logic           oa, ob, noa, tc, busy, cmd_err;
  logic [3:0]     brk, nobrk;
  logic [7:0]     ocnt;
  logic           oa3, ob3, noa3, tc3, busy3, cmd_err3;
  logic [2:0]     brk3, nobrk3;
  logic [7:0]     ocnt3;

  cpu_debug_slave_sysclk_mc #(
    .SR_WIDTH(SrW), .IR_WIDTH(2), .NUM_BRK(4), .SYNC_STAGES(Sync)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ocimem_ready(ocimem_ready), .jdo(jdo), .take_action_ocimem_a(oa),
    .take_action_ocimem_b(ob), .take_no_action_ocimem_a(noa), .take_action_brk(brk),
    .take_no_action_brk(nobrk), .take_action_tracectrl(tc), .busy(busy), .cmd_err(cmd_err),
    .overrun_cnt(ocnt)
  );

  cpu_debug_slave_sysclk_mc #(
    .SR_WIDTH(SrW), .IR_WIDTH(2), .NUM_BRK(3), .SYNC_STAGES(Sync)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ocimem_ready(ocimem_ready), .jdo(jdo3), .take_action_ocimem_a(oa3),
    .take_action_ocimem_b(ob3), .take_no_action_ocimem_a(noa3), .take_action_brk(brk3),
    .take_no_action_brk(nobrk3), .take_action_tracectrl(tc3), .busy(busy3),
    .cmd_err(cmd_err3), .overrun_cnt(ocnt3)
  );

  always #5 clk = ~clk;

`ifdef DBG_SLAVE_OVERRUN_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  // Action vector layout: {oa, ob, noa, tc, brk[3:0], nobrk[3:0]}
  localparam logic [11:0] BitOa = 12'h800, BitOb = 12'h400, BitNoa = 12'h200, BitTc = 12'h100;

  int n_checks = 0, n_err = 0;
  int cyc = 0;
  int act_cycles, err_cycles, first_cyc, multi_hot = 0;
  logic [11:0] act_or;
  int err3_cycles;
  logic [2:0]  brk3_or;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] act_vec();
    return {oa, ob, noa, tc, brk, nobrk};
  endfunction

  // Expected outcome of one command from the IR/scan-bit rules, independent of timing.
  function automatic logic [11:0] model_act(input logic [1:0] ir, input logic [SrW-1:0] s,
                                            output logic err);
    logic [11:0] v;
    int unsigned idx;
    logic a, sl, ba;
    v   = '0;
    err = 1'b0;
    idx = s[SrW-1 -: 2];
    a   = s[SrW-3];
    sl  = s[SrW-4];
    ba  = s[SrW-3];
    case (ir)
      2'd0: v = !a ? BitNoa : (sl ? BitOb : BitOa);
      2'd2: if (idx < 4) v = ba ? (12'h010 << idx) : (12'h001 << idx);
            else err = 1'b1;
      2'd3: v = a ? BitTc : 12'h000;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [11:0] cur;
    cur = act_vec();
    if (cur != 0) begin
      act_cycles++;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if ($countones(cur) > 1 || $countones({oa3, ob3, noa3, tc3, brk3, nobrk3}) > 1) multi_hot++;
    act_or = act_or | cur;
    if (cmd_err) err_cycles++;
    if (cmd_err3) err3_cycles++;
    brk3_or = brk3_or | brk3 | nobrk3;
  end

  task automatic clr_mon();
    act_cycles = 0; err_cycles = 0; first_cyc = -1; act_or = '0;
    err3_cycles = 0; brk3_or = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    wait_cyc(Sync + 2);
    vs_uir = 1'b0;
    wait_cyc(Sync + 2);
  endtask

  // c0 is the cycle count just after the edge preceding the vs_udr rise.
  task automatic udr_pulse(output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
    vs_udr = 1'b1;
    wait_cyc(Sync + 1);
    vs_udr = 1'b0;
  endtask

  initial begin
    int c0;
    logic [SrW-1:0] s0, s1;
    logic [11:0] exp_v;
    logic exp_e;
    clr_mon();

    wait_cyc(3);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_jdo", jdo, 0);
    check_eq("rst_act", act_vec(), 0);
    check_eq("rst_err", cmd_err, 0);
    check_eq("rst_cnt", ocnt, 0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(2);

    // Break channel 2 write, with latency measured in edges up to the consumer's sample edge.
    set_ir(2'd2);
    s0 = {$urandom, $urandom};
    s0[SrW-1 -: 3] = 3'b101;
    sr = s0;
    clr_mon();
    udr_pulse(c0);
    wait_cyc(8);
    check_eq("t1_brk", act_or, 12'h040);
    check_eq("t1_cycles", act_cycles, 1);
    check_eq("t1_latency", first_cyc - c0 + 1, Sync + 3);
    check_eq("t1_jdo", jdo, s0);

    // ocimem write stalled by ready=0.
    set_ir(2'd0);
    s0 = {$urandom, $urandom};
    s0[SrW-3 -: 2] = 2'b10;
    sr = s0;
    ocimem_ready = 1'b0;
    clr_mon();
    udr_pulse(c0);
    wait_cyc(4);
    sr = {$urandom, $urandom};
    wait_cyc(5);
    @(negedge clk);
    check_eq("t2_busy", busy, 1);
    check_eq("t2_noact", act_cycles, 0);
    check_eq("t2_jdo", jdo, s0);
    @(posedge clk);
    #1;
    ocimem_ready = 1'b1;
    @(negedge clk);
    check_eq("t2_oa_now", oa, 1);
    wait_cyc(1);
    @(negedge clk);
    check_eq("t2_idle", busy, 0);
    check_eq("t2_cycles", act_cycles, 1);

    // Overrun during stall.
    s0 = {$urandom, $urandom};
    s0[SrW-3 -: 2] = 2'b11;
    sr = s0;
    ocimem_ready = 1'b0;
    clr_mon();
    udr_pulse(c0);
    wait_cyc(6);
    s1 = ~s0;
    sr = s1;
    udr_pulse(c0);
    wait_cyc(6);
    check_eq("t3_err", err_cycles, 1);
    check_eq("t3_cnt", ocnt, CntEn ? 1 : 0);
    check_eq("t3_jdo", jdo, s0);
    check_eq("t3_noact", act_cycles, 0);
    ocimem_ready = 1'b1;
    wait_cyc(3);
    check_eq("t3_ob", act_or, BitOb);
    check_eq("t3_cycles", act_cycles, 1);
    check_eq("t3_idle", busy, 0);

    // Break index 3: valid on the 4-channel part, out of range on the 3-channel part.
    set_ir(2'd2);
    s0 = {$urandom, $urandom};
    s0[SrW-1 -: 2] = 2'b11;
    sr = s0;
    clr_mon();
    udr_pulse(c0);
    wait_cyc(8);
    check_eq("t4_err3", err3_cycles, 1);
    check_eq("t4_brk3", brk3_or, 0);
    check_eq("t4_busy3", busy3, 0);
    check_eq("t4_brk4", act_or, s0[SrW-3] ? 12'h080 : 12'h008);
    check_eq("t4_err4", err_cycles, 0);

    // Randomised commands against the model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] ir;
      ir = 2'($urandom_range(0, 3));
      set_ir(ir);
      s0 = {$urandom, $urandom};
      sr = s0;
      exp_v = model_act(ir, s0, exp_e);
      ocimem_ready = 1'($urandom_range(0, 1));
      clr_mon();
      udr_pulse(c0);
      wait_cyc(Sync + 3 + $urandom_range(0, 3));
      ocimem_ready = 1'b1;
      wait_cyc(4);
      check_eq($sformatf("rnd%0d_act", t), act_or, exp_v);
      check_eq($sformatf("rnd%0d_cyc", t), act_cycles, exp_v != 0 ? 1 : 0);
      check_eq($sformatf("rnd%0d_err", t), err_cycles, exp_e);
      check_eq($sformatf("rnd%0d_jdo", t), jdo, s0);
      check_eq($sformatf("rnd%0d_idle", t), busy, 0);
    end

    // Reset during stall.
    set_ir(2'd0);
    s0 = {$urandom, $urandom};
    s0[SrW-3] = 1'b1;
    sr = s0;
    ocimem_ready = 1'b0;
    udr_pulse(c0);
    wait_cyc(6);
    check_eq("t5_stall", busy, 1);
    clr_mon();
    reset_n = 1'b0;
    ocimem_ready = 1'b1;
    wait_cyc(1);
    @(negedge clk);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_jdo", jdo, 0);
    check_eq("t5_act", act_vec(), 0);
    check_eq("t5_err", cmd_err, 0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(10);
    check_eq("t5_nopulse", act_cycles, 0);

    // 300 overruns, then a trace-control write.
    set_ir(2'd0);
    s0 = {$urandom, $urandom};
    s0[SrW-3] = 1'b0;
    sr = s0;
    ocimem_ready = 1'b0;
    udr_pulse(c0);
    wait_cyc(6);
    clr_mon();
    for (int k = 0; k < 300; k++) begin
      vs_udr = 1'b1;
      wait_cyc(Sync + 1);
      vs_udr = 1'b0;
      wait_cyc(Sync + 1);
    end
    wait_cyc(2);
    check_eq("t6_errs", err_cycles, 300);
    check_eq("t6_cnt", ocnt, CntEn ? 255 : 0);
    check_eq("t6_busy", busy, 1);
    ocimem_ready = 1'b1;
    wait_cyc(3);
    check_eq("t6_noa", act_or, BitNoa);
    check_eq("t6_noa_cyc", act_cycles, 1);
    set_ir(2'd3);
    s0 = {$urandom, $urandom};
    s0[SrW-3] = 1'b1;
    sr = s0;
    clr_mon();
    udr_pulse(c0);
    wait_cyc(8);
    check_eq("t6_tc", act_or, BitTc);
    check_eq("t6_tc_cyc", act_cycles, 1);

    check_eq("onehot", multi_hot, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
